// File: rtl/async_fifo_rd_ctrl.sv
// Read-side controller of an asynchronous FIFO: synchronizes the write pointer,
// derives empty/occupancy, and drives a one-word registered output stage.
`timescale 1ns/1ps
module async_fifo_rd_ctrl #(
    parameter int AW = 3,
    parameter int W  = 8
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic [AW:0]   wr_ptr_gray,
    output logic [AW:0]   rd_ptr_gray,
    output logic [AW-1:0] mem_raddr,
    input  logic [W-1:0]  mem_rdata,
    output logic [W-1:0]  dout,
    output logic          dout_valid,
    input  logic          dout_ready,
    output logic          empty,
    output logic [AW:0]   rd_count,
    output logic          ptr_err
);

    // Handshake: a word moves out on a clk edge where dout_valid and dout_ready
    // are both high; dout_valid never drops and dout never changes while
    // dout_ready is low.

    typedef enum logic {
        IDLE = 1'b0,
        FULL = 1'b1
    } state_t;

    localparam logic [AW:0] DEPTH = (AW+1)'(1) << AW;

    state_t      state;
    state_t      state_next;
    logic [AW:0] wsync1;
    logic [AW:0] wsync2;
    logic [AW:0] wbin;
    logic [AW:0] rptr;
    logic [AW:0] rptr_next;
    logic        fetch;

    function automatic logic [AW:0] gray2bin(input logic [AW:0] g);
        logic [AW:0] b;
        b[AW] = g[AW];
        for (int i = AW - 1; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    assign wbin      = gray2bin(wsync2);
    assign rptr_next = rptr + (AW+1)'(1);
    assign mem_raddr = rptr[AW-1:0];
    // Both operands are registers, so empty is glitch-free in this domain.
    assign empty     = (rd_ptr_gray == wsync2);
    assign rd_count  = wbin - rptr;
    assign fetch     = !empty && (!dout_valid || dout_ready);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (fetch) state_next = FULL;
            FULL: begin
                if (fetch) begin
                    state_next = FULL;
                end else if (dout_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        dout_valid = (state == FULL);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wsync1      <= '0;
            wsync2      <= '0;
            rptr        <= '0;
            rd_ptr_gray <= '0;
            dout        <= '0;
            ptr_err     <= 1'b0;
        end else begin
            wsync1  <= wr_ptr_gray;
            wsync2  <= wsync1;
            // More than DEPTH unread words means the pointers are corrupt.
            ptr_err <= ptr_err | (rd_count > DEPTH);
            if (fetch) begin
                dout        <= mem_rdata;
                rptr        <= rptr_next;
                rd_ptr_gray <= rptr_next ^ (rptr_next >> 1);
            end
        end
    end

endmodule

// File: doc/async_fifo_rd_ctrl.md
ASYNC_FIFO_RD_CTRL -- requirements
Module: async_fifo_rd_ctrl

Interface
REQ-001 Parameter AW, default 3, FIFO address width; depth = 2**AW.
REQ-002 Parameter W, default 8, data word width.
REQ-003 clk  input  1  read-domain clock; the block has this one clock only.
REQ-004 resetn  input  1  reset, asynchronous, active-low.
REQ-005 wr_ptr_gray  input  AW+1  write pointer, Gray coded, asynchronous to clk.
REQ-006 rd_ptr_gray  output  AW+1  read pointer, Gray coded, registered, for the write domain.
REQ-007 mem_raddr  output  AW  storage read address.
REQ-008 mem_rdata  input  W  storage read data, combinational from mem_raddr.
REQ-009 dout  output  W  output data word.
REQ-010 dout_valid  output  1  dout holds a valid word.
REQ-011 dout_ready  input  1  consumer accepts dout this cycle.
REQ-012 empty  output  1  no unread word in storage, as seen in the read domain.
REQ-013 rd_count  output  AW+1  unread words in storage, excluding the word in dout.
REQ-014 ptr_err  output  1  sticky flag: illegal pointer distance detected.

Function
REQ-015 wr_ptr_gray SHALL pass through a 2-flop synchronizer (wsync1, wsync2) before any use.
REQ-016 wbin SHALL be the Gray-to-binary conversion of wsync2: msb copied; each lower bit = next-higher binary bit XOR own Gray bit.
REQ-017 rptr SHALL be an AW+1-bit binary register that wraps modulo 2**(AW+1).
REQ-018 rd_ptr_gray SHALL be a register loaded with (rptr_next XOR (rptr_next >> 1)) whenever rptr loads, so at most one bit changes per increment.
REQ-019 mem_raddr SHALL equal rptr[AW-1:0].
REQ-020 empty SHALL equal (rd_ptr_gray == wsync2), decoded combinationally from registers only.
REQ-021 rd_count SHALL equal (wbin - rptr) modulo 2**(AW+1).
REQ-022 fetch = !empty AND (!dout_valid OR dout_ready).
REQ-023 On fetch: dout <= mem_rdata, dout_valid <= 1, rptr increments by 1.
REQ-024 Word taken with no fetch (dout_valid AND dout_ready AND empty): dout_valid <= 0; dout holds its last value.
REQ-025 Output state machine: IDLE (dout_valid=0) -> FULL on fetch; FULL -> FULL on fetch; FULL -> IDLE on taken word with no fetch; FULL holds while dout_ready=0.
REQ-026 While dout_valid=1 and dout_ready=0, dout and rptr SHALL NOT change.
REQ-027 Latency: a wr_ptr_gray change set up before edge E0 SHALL deassert empty after E1 and assert dout_valid after E2.
REQ-028 Throughput: with dout_ready held high and storage non-empty, one word per cycle, no bubbles.
REQ-029 Pointer wrap: rptr from 2**(AW+1)-1 to 0 SHALL be a normal increment with no extra cycle and no change to empty or rd_count.
REQ-030 rd_count > 2**AW SHALL set ptr_err; it stays set until reset; no other behaviour changes.
REQ-031 Reading is only possible through fetch; nothing is read when empty=1, so underflow cannot occur.

Reset
REQ-032 resetn low SHALL clear immediately, without waiting for clk: wsync1, wsync2, rptr, rd_ptr_gray, dout, dout_valid, ptr_err.
REQ-033 Reset values: empty=1 when wr_ptr_gray has propagated as 0, rd_count=0, mem_raddr=0.
REQ-034 Reset asserted mid-transfer SHALL discard the word held in dout; the block keeps no state across reset.
REQ-035 resetn deassertion is synchronous to clk; a reset synchronizer outside this block provides that.

Verification
REQ-036 Reset, then wr_ptr_gray=0 held -> empty=1, dout_valid=0, rd_count=0, rd_ptr_gray=0, ptr_err=0.
REQ-037 wr_ptr_gray 0->1 before E0, mem_rdata=8'hA5 at addr 0 -> empty=0 after E1; dout=8'hA5 and dout_valid=1 after E2; rd_ptr_gray=1.
REQ-038 8 words written (wr_ptr_gray = gray(8) = 4'b1100), dout_ready=1 -> 8 consecutive valid words, addr 0..7, then empty=1 and rd_ptr_gray=4'b1100.
REQ-039 dout_valid=1, dout_ready=0 for 5 cycles with 3 words pending -> dout stable, rptr frozen, rd_count=3.
REQ-040 Run 20 words through with the writer just ahead -> rptr wraps 15->0 with no stall; rd_ptr_gray shows 1-bit changes only.
REQ-041 Force wr_ptr_gray to a distance of 10 -> ptr_err=1 after 2 cycles and stays 1 until resetn is pulsed.
